// File: rtl/free_proposer_arbiter_pkg.sv
// free_proposer_arbiter_pkg: shared sizes and FSM state type for the free-proposer arbiter
package free_proposer_arbiter_pkg;
  localparam int LOG_S = 4;
  localparam int PROP_CNT_W = 2 * LOG_S + 1;
  typedef enum logic [1:0] {IDLE, ARB, WAIT, DONE} state_t;
endpackage

// File: rtl/free_proposer_arbiter_if.sv
// free_proposer_arbiter_if: run control, grant handshake and release port of the arbiter
interface free_proposer_arbiter_if import free_proposer_arbiter_pkg::*; #(parameter int logS = LOG_S);
  logic                  start;
  logic [2**logS-1:0]    grant_oh;
  logic                  grant_valid;
  logic                  grant_ready;
  logic                  release_valid;
  logic [logS-1:0]       release_idx;
  logic                  done;
  logic [2*logS:0]       prop_count;
  modport master (output start, grant_ready, release_valid, release_idx,
                  input grant_oh, grant_valid, done, prop_count);
  modport slave (input start, grant_ready, release_valid, release_idx,
                 output grant_oh, grant_valid, done, prop_count);
endinterface

// File: rtl/encoder.sv
// encoder: one-hot to binary index
module encoder import free_proposer_arbiter_pkg::*; #(parameter int logS = LOG_S) (
  input  logic [2**logS-1:0] oh,
  output logic [logS-1:0]    idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < 2**logS; i++) idx = oh[i] ? idx | logS'(i) : idx;
  end
endmodule

// File: rtl/free_proposer_arbiter_rr_pick.sv
// rr_pick: round-robin find-first-set of free starting at ptr, wrapping to bit 0
module rr_pick import free_proposer_arbiter_pkg::*; #(parameter int logS = LOG_S) (
  input  logic [2**logS-1:0] free,
  input  logic [logS-1:0]    ptr,
  output logic [2**logS-1:0] pick
);
  localparam int S = 2**logS;
  logic [S-1:0] masked;
  assign masked = free & ~((S'(1) << ptr) - S'(1));
  assign pick = |masked ? masked & (~masked + S'(1)) : free & (~free + S'(1));
endmodule

// File: rtl/free_proposer_arbiter.sv
// free_proposer_arbiter: tracks free proposers and issues them one at a time as a one-hot grant
module free_proposer_arbiter import free_proposer_arbiter_pkg::*; #(parameter int logS = LOG_S) (
  input logic clk,
  input logic rst_n,
  free_proposer_arbiter_if.slave bus
);
  localparam int S = 2**logS;
  localparam int CW = 2 * logS + 1;
  state_t state, state_n;
  logic [S-1:0] free, free_n, pick, grant_oh, oh_n;
  logic [logS-1:0] ptr, ptr_n, g;
  logic [CW-1:0] cnt, cnt_n;
  logic hs, idle_like;
  rr_pick #(.logS(logS)) u_pick (.free(free), .ptr(ptr), .pick(pick));
  encoder #(.logS(logS)) u_enc (.oh(grant_oh), .idx(g));
  assign hs = state == WAIT && bus.grant_ready;
  assign idle_like = state == IDLE || state == DONE;
  assign bus.grant_oh = grant_oh;
  assign bus.grant_valid = state == WAIT;
  assign bus.done = state == DONE;
  assign bus.prop_count = cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      free <= '0;
      ptr <= '0;
      grant_oh <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      free <= free_n;
      ptr <= ptr_n;
      grant_oh <= oh_n;
      cnt <= cnt_n;
    end
  // release is applied after the handshake clear so a same-index release leaves the bit set
  always_comb begin
    state_n = state;
    free_n = free;
    ptr_n = ptr;
    oh_n = grant_oh;
    cnt_n = cnt;
    if (hs) begin
      free_n[g] = 1'b0;
      ptr_n = g + logS'(1);
      cnt_n = &cnt ? cnt : cnt + CW'(1);
      oh_n = '0;
      state_n = ARB;
    end
    if (bus.release_valid && state != IDLE) free_n[bus.release_idx] = 1'b1;
    if (state == ARB) begin
      state_n = |free ? WAIT : DONE;
      oh_n = |free ? pick : '0;
    end
    if (state == DONE && bus.release_valid) state_n = ARB;
    if (idle_like && bus.start) begin
      state_n = ARB;
      free_n = '1;
      ptr_n = '0;
      cnt_n = '0;
      oh_n = '0;
    end
  end
endmodule

// File: tb/tb_free_proposer_arbiter.sv
// tb_free_proposer_arbiter: directed-vector bench for free_proposer_arbiter at logS=2
module tb_free_proposer_arbiter;
  logic clk = 0;
  logic rst_n = 0;
  int nvec = 0;
  int nerr = 0;
  free_proposer_arbiter_if #(.logS(2)) bus();
  free_proposer_arbiter #(.logS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_start;
    bus.start = 1;
    tick;
    bus.start = 0;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.grant_ready = 0; bus.release_valid = 0; bus.release_idx = 0;
    rst_n = 0;
    tick; tick;
    nvec++;
    if (bus.grant_oh !== 4'b0 || bus.grant_valid !== 1'b0 || bus.done !== 1'b0 || bus.prop_count !== 5'd0) begin
      nerr++;
      $display("FAIL reset: oh=%b valid=%b done=%b cnt=%0d, want 0000/0/0/0", bus.grant_oh, bus.grant_valid, bus.done, bus.prop_count);
    end
    rst_n = 1;
    tick;
  endtask

  task automatic test_sweep;
    bus.grant_ready = 1;
    do_start;
    for (int i = 0; i < 4; i++) begin
      tick;
      nvec++;
      if (bus.grant_valid !== 1'b1 || bus.grant_oh !== 4'(1 << i)) begin
        nerr++;
        $display("FAIL sweep grant %0d: oh=%b valid=%b, want %b/1", i, bus.grant_oh, bus.grant_valid, 4'(1 << i));
      end
      tick;
      nvec++;
      if (bus.grant_valid !== 1'b0 || bus.grant_oh !== 4'b0) begin
        nerr++;
        $display("FAIL sweep bubble %0d: oh=%b valid=%b, want 0000/0", i, bus.grant_oh, bus.grant_valid);
      end
    end
    tick;
    nvec++;
    if (bus.done !== 1'b1 || bus.prop_count !== 5'd4 || bus.grant_valid !== 1'b0) begin
      nerr++;
      $display("FAIL sweep done: done=%b cnt=%0d valid=%b, want 1/4/0", bus.done, bus.prop_count, bus.grant_valid);
    end
  endtask

  task automatic test_hold;
    bus.grant_ready = 0;
    do_start;
    tick;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 0);
      tick;
      bus.start = 0;
      nvec++;
      if (bus.grant_valid !== 1'b1 || bus.grant_oh !== 4'b0001 || bus.prop_count !== 5'd0) begin
        nerr++;
        $display("FAIL hold cycle %0d: oh=%b valid=%b cnt=%0d, want 0001/1/0", i, bus.grant_oh, bus.grant_valid, bus.prop_count);
      end
    end
    bus.grant_ready = 1;
    tick; tick;
    nvec++;
    if (bus.grant_valid !== 1'b1 || bus.grant_oh !== 4'b0010) begin
      nerr++;
      $display("FAIL hold next: oh=%b valid=%b, want 0010/1", bus.grant_oh, bus.grant_valid);
    end
    for (int k = 0; k < 20 && bus.done !== 1'b1; k++) tick;
    nvec++;
    if (bus.done !== 1'b1) begin
      nerr++;
      $display("FAIL hold drain: done=%b, want 1 within 20 cycles", bus.done);
    end
  endtask

  task automatic test_release_reissue;
    logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.grant_ready = 1;
    do_start;
    tick;
    nvec++;
    if (bus.grant_oh !== 4'b0001) begin
      nerr++;
      $display("FAIL reissue first: oh=%b, want 0001", bus.grant_oh);
    end
    bus.release_valid = 1; bus.release_idx = 0;
    tick;
    bus.release_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      nvec++;
      if (bus.grant_valid !== 1'b1 || bus.grant_oh !== exp[i]) begin
        nerr++;
        $display("FAIL reissue order %0d: oh=%b valid=%b, want %b/1", i, bus.grant_oh, bus.grant_valid, exp[i]);
      end
      tick;
    end
    tick;
    nvec++;
    if (bus.done !== 1'b1 || bus.prop_count !== 5'd5) begin
      nerr++;
      $display("FAIL reissue done: done=%b cnt=%0d, want 1/5", bus.done, bus.prop_count);
    end
  endtask

  task automatic test_done_release;
    bus.grant_ready = 1;
    bus.release_valid = 1; bus.release_idx = 2;
    tick;
    bus.release_valid = 0;
    nvec++;
    if (bus.done !== 1'b0 || bus.grant_valid !== 1'b0) begin
      nerr++;
      $display("FAIL done release drop: done=%b valid=%b, want 0/0", bus.done, bus.grant_valid);
    end
    tick;
    nvec++;
    if (bus.grant_oh !== 4'b0100 || bus.grant_valid !== 1'b1) begin
      nerr++;
      $display("FAIL done release grant: oh=%b valid=%b, want 0100/1", bus.grant_oh, bus.grant_valid);
    end
    tick; tick;
    nvec++;
    if (bus.done !== 1'b1 || bus.prop_count !== 5'd6) begin
      nerr++;
      $display("FAIL done return: done=%b cnt=%0d, want 1/6", bus.done, bus.prop_count);
    end
    bus.release_valid = 1; bus.release_idx = 0;
    tick;
    bus.release_valid = 0;
    tick;
    nvec++;
    if (bus.grant_oh !== 4'b0001 || bus.grant_valid !== 1'b1) begin
      nerr++;
      $display("FAIL wrap from ptr3: oh=%b valid=%b, want 0001/1", bus.grant_oh, bus.grant_valid);
    end
    tick; tick;
    nvec++;
    if (bus.done !== 1'b1 || bus.prop_count !== 5'd7) begin
      nerr++;
      $display("FAIL wrap done: done=%b cnt=%0d, want 1/7", bus.done, bus.prop_count);
    end
  endtask

  task automatic test_wraparound;
    bus.grant_ready = 1;
    do_start;
    for (int i = 0; i < 3; i++) begin
      tick;
      nvec++;
      if (bus.grant_oh !== 4'(1 << i)) begin
        nerr++;
        $display("FAIL wrap setup %0d: oh=%b, want %b", i, bus.grant_oh, 4'(1 << i));
      end
      tick;
    end
    tick;
    bus.release_valid = 1; bus.release_idx = 1;
    tick;
    bus.release_valid = 0; bus.grant_ready = 0;
    tick;
    nvec++;
    if (bus.grant_oh !== 4'b0010) begin
      nerr++;
      $display("FAIL wrap regrant: oh=%b, want 0010", bus.grant_oh);
    end
    bus.release_valid = 1; bus.release_idx = 3;
    tick;
    bus.grant_ready = 1; bus.release_idx = 0;
    tick;
    bus.release_valid = 0;
    tick;
    nvec++;
    if (bus.grant_oh !== 4'b1000) begin
      nerr++;
      $display("FAIL wrap ptr2: oh=%b, want 1000", bus.grant_oh);
    end
    tick; tick;
    nvec++;
    if (bus.grant_oh !== 4'b0001) begin
      nerr++;
      $display("FAIL wrap ptr0: oh=%b, want 0001", bus.grant_oh);
    end
    tick; tick;
    nvec++;
    if (bus.done !== 1'b1) begin
      nerr++;
      $display("FAIL wrap end: done=%b, want 1", bus.done);
    end
  endtask

  task automatic test_midrun_reset;
    bus.grant_ready = 0;
    do_start;
    tick;
    bus.start = 1;
    tick;
    bus.start = 0;
    nvec++;
    if (bus.grant_valid !== 1'b1 || bus.grant_oh !== 4'b0001 || bus.prop_count !== 5'd0) begin
      nerr++;
      $display("FAIL start in WAIT: oh=%b valid=%b cnt=%0d, want 0001/1/0", bus.grant_oh, bus.grant_valid, bus.prop_count);
    end
    #2 rst_n = 0;
    #1;
    nvec++;
    if (bus.grant_oh !== 4'b0 || bus.grant_valid !== 1'b0 || bus.done !== 1'b0 || bus.prop_count !== 5'd0) begin
      nerr++;
      $display("FAIL async reset: oh=%b valid=%b done=%b cnt=%0d, want 0000/0/0/0", bus.grant_oh, bus.grant_valid, bus.done, bus.prop_count);
    end
    tick;
    rst_n = 1;
    bus.release_valid = 1; bus.release_idx = 1;
    tick;
    bus.release_valid = 0;
    tick;
    nvec++;
    if (bus.grant_valid !== 1'b0 || bus.done !== 1'b0) begin
      nerr++;
      $display("FAIL release in IDLE: valid=%b done=%b, want 0/0", bus.grant_valid, bus.done);
    end
  endtask

  task automatic test_saturation;
    bus.grant_ready = 1;
    do_start;
    for (int i = 0; i < 33; i++) begin
      tick;
      nvec++;
      if (bus.grant_oh !== 4'(1 << (i % 4))) begin
        nerr++;
        $display("FAIL sat grant %0d: oh=%b, want %b", i, bus.grant_oh, 4'(1 << (i % 4)));
      end
      bus.release_valid = 1; bus.release_idx = 2'(i % 4);
      tick;
      bus.release_valid = 0;
      nvec++;
      if (bus.prop_count !== 5'((i + 1 > 31) ? 31 : i + 1)) begin
        nerr++;
        $display("FAIL sat count %0d: cnt=%0d, want %0d", i, bus.prop_count, (i + 1 > 31) ? 31 : i + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_hold;
    test_release_reissue;
    test_done_release;
    test_wraparound;
    test_midrun_reset;
    test_saturation;
    rst_n = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
